// File: rtl/vga_pkg.sv
// Shared VGA definitions: arbiter slot encodings and default pixel/address widths
// used by the timing, colour and memory-arbitration blocks.
package vga_pkg;

  localparam int VGA_ADDR_W = 17;
  localparam int VGA_DATA_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Bundle of display-fetch, drawing-engine and pixel-memory signals around the arbiter.
// slave = the arbiter's view, master = the surrounding logic's view.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = vga_pkg::VGA_ADDR_W,
  parameter int DATA_W = vga_pkg::VGA_DATA_W
);

  logic              video_on;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              starve_clr;
  logic              wr_starve;

  modport slave (
    input  video_on, disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata, starve_clr,
    output disp_gnt, disp_rvalid, disp_rdata, wr_ack, mem_addr, mem_we, mem_wdata, wr_starve
  );

  modport master (
    output video_on, disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata, starve_clr,
    input  disp_gnt, disp_rvalid, disp_rdata, wr_ack, mem_addr, mem_we, mem_wdata, wr_starve
  );

endinterface

// File: rtl/vga_rd_valid_pipe.sv
// Tracks read slots through the memory's read latency: a '1' entering on the RD
// slot cycle emerges RD_LAT cycles later as the read-data-valid strobe.
module vga_rd_valid_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic slot_rd_i,
  output logic rvalid_o
);

  logic [RD_LAT-1:0] pipe_q;

  generate
    if (RD_LAT == 1) begin : g_single
      // Single-stage delay; reset flushes any in-flight read.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= slot_rd_i;
      end
    end else begin : g_multi
      // Shift the RD slot indicator toward the output; reset flushes in-flight reads.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) pipe_q <= '0;
        else       pipe_q <= {pipe_q[RD_LAT-2:0], slot_rd_i};
      end
    end
  endgenerate

  assign rvalid_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port pixel memory arbiter. Display reads always win; writes fill the
// remaining slots (optionally only during blanking) and never occupy two slots
// in a row. A sticky flag reports a writer that has waited too long.
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W        = VGA_ADDR_W,
  parameter int DATA_W        = VGA_DATA_W,
  parameter int RD_LAT        = 2,
  parameter int WR_BLANK_ONLY = 0,
  parameter int STARVE_MAX    = 64
) (
  input  logic              clk,
  input  logic              reset,
  vga_mem_arbiter_if.slave  bus
);

  localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              wr_starve_q, wr_starve_d;
  logic              wr_allowed;
  logic              disp_gnt;
  logic              wr_ack;
  logic              disp_rvalid;

  // Writes may be issued at any time, or only while the beam is blanked.
  assign wr_allowed = (WR_BLANK_ONLY == 0) || !bus.video_on;

  // Next slot: display read first, then a write unless the current slot is already a write.
  always_comb begin
    state_d = ST_IDLE;
    if (bus.disp_req) begin
      state_d = ST_RD;
    end else if (bus.wr_req && (state_q != ST_WR) && wr_allowed) begin
      state_d = ST_WR;
    end
  end

  // Slot register: the state names what the memory port is doing this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Memory port registers load alongside the slot they belong to; idle holds addr/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      case (state_d)
        ST_RD: begin
          mem_addr_q <= bus.disp_addr;
          mem_we_q   <= 1'b0;
        end
        ST_WR: begin
          mem_addr_q  <= bus.wr_addr;
          mem_wdata_q <= bus.wr_data;
          mem_we_q    <= 1'b1;
        end
        default: mem_we_q <= 1'b0;
      endcase
    end
  end

  assign disp_gnt = (state_q == ST_RD);
  assign wr_ack   = (state_q == ST_WR);

  // Starvation tracking: count unserved write-request cycles; a new saturation beats a clear.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.wr_req || wr_ack) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    wr_starve_d = wr_starve_q;
    if (starve_cnt_d == CNT_MAX) begin
      wr_starve_d = 1'b1;
    end else if (bus.starve_clr) begin
      wr_starve_d = 1'b0;
    end
  end

  // Starvation counter and sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_q <= '0;
      wr_starve_q  <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_starve_q  <= wr_starve_d;
    end
  end

  vga_rd_valid_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_valid_pipe (
    .clk       (clk),
    .reset     (reset),
    .slot_rd_i (disp_gnt),
    .rvalid_o  (disp_rvalid)
  );

  assign bus.disp_gnt    = disp_gnt;
  assign bus.wr_ack      = wr_ack;
  assign bus.disp_rvalid = disp_rvalid;
  assign bus.disp_rdata  = bus.mem_rdata;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.wr_starve   = wr_starve_q;

endmodule
